melody_sequencer: RTL and testbench
===================================

Name: melody_sequencer

Overview:
Upstream note source for the note display and tone generator. Steps through a fixed 16-entry melody ROM and drives the 12-bit `freq` bus with the frequency (Hz) of the current note, or 0 during rests. It supports play/pause, restart, a 2-bit tempo select, and optional looping. `freq` feeds the 7-segment note display directly, and that display shows '-' for any frequency it does not recognise, including 0.

Parameters:
TICK_DIV, 6250000, clock cycles per beat tick at tempo 0; legal range 8..2^24-1
LOOP, 0, 1 = wrap from entry 15 back to entry 0; 0 = stop in DONE after entry 15

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
play  in  1  level; 1 = run, 0 = pause
restart  in  1  single-cycle pulse; return to entry 0 and go idle
tempo  in  2  tick divisor = TICK_DIV >> tempo
freq  out  12  current note frequency in Hz, registered; 0 = silence
note_idx  out  4  ROM index of the current note
busy  out  1  1 in PLAY or PAUSE
done  out  1  1 in DONE (level)

Behaviour:
- Clocking and reset: one clock, `clk`. `rst` is synchronous, active-high, and has top priority. Reset values: state = IDLE, `freq` = 0, `note_idx` = 0, `busy` = 0, `done` = 0; tick counter, remaining-tick count and divisor register all cleared.
- ROM entry format: 4-bit note code plus 4-bit duration field. Duration in ticks = field + 1 (1..16).
- Code map: 1=261, 2=277, 3=293, 4=311, 5=330, 6=349, 7=370, 8=392, 9=415, 10=440, 11=466, 12=494. Code 0 (rest) and codes 13..15 map to 0.
- ROM contents, idx:code/field: 0:1/0 1:3/0 2:5/0 3:6/0 4:8/1 5:10/1 6:12/1 7:0/0 8:2/3 9:4/0 10:7/0 11:9/0 12:11/0 13:13/0 14:10/15 15:1/0. Total = 37 ticks.
- Note load (one edge): `note_idx` <= idx; `freq` <= map(code); remaining <= field+1; tick counter <= 0; divisor register <= TICK_DIV >> tempo. Tempo is sampled only at note load.
- Tick: the counter runs 0..div-1 while in PLAY. A tick occurs on the cycle the counter equals div-1, and the counter wraps to 0. Each tick decrements remaining.
- Note end: a tick with remaining == 1 ends the note. The next entry loads on that same edge, so each note occupies exactly (field+1)*div cycles with no gap.
- IDLE: `freq` = 0. When `play` = 1 at an edge, go to PLAY and load the entry at `note_idx` on that edge. `freq` is valid the following cycle.
- PLAY:
  - `play` = 0 → PAUSE; `freq` <= 0; counter and remaining freeze.
  - Note end at idx 15: with LOOP = 1, load entry 0 and stay in PLAY. With LOOP = 0, go to DONE with `freq` <= 0 and `note_idx` held at 15.
- PAUSE: `freq` = 0, all counters held. When `play` = 1 → PLAY; `freq` <= map(current code) and counting resumes from the frozen values. Tempo is not resampled on resume.
- DONE: `done` = 1, `busy` = 0, `freq` = 0. Leaves only on `restart` or `rst`.
- `restart` (any state, below `rst` in priority): state <= IDLE, `note_idx` <= 0, `freq` <= 0, counters cleared, `done` <= 0. If `play` is still high, PLAY is entered on the next edge.
- Simultaneous events:
  - `play` falling on the same cycle as a note-end tick: the advance and load complete, then PAUSE takes effect. The stored state is the new note with a fresh count.
  - `restart` together with `play` = 1 in IDLE: restart wins, and entry is delayed one cycle.
- `busy` and `done` are registered and change on the same edge as the state.

Test Plan:
- TICK_DIV=8, tempo=0, LOOP=0; reset, then `play`=1 held → `freq`=261 for 8 cycles, 293 for 8, 330, 349, then 392 for 16; `busy`=1.
- Same config, run to completion → 37 ticks = 296 cycles of notes; idx 7 and idx 13 give `freq`=0; idx 14 gives 440 for 128 cycles; then `done`=1, `freq`=0, `note_idx`=15, stable for 100+ cycles.
- LOOP=1 → after idx 15 (261 for 8 cycles) `freq` returns to 261 at idx 0 with no gap; `done` stays 0.
- Pause: drop `play` 3 cycles into idx 1 → `freq`=0 and held; raise `play` 20 cycles later → 293 for the remaining 5 cycles, then 330.
- Tempo: tempo=1 at reset/play → 4-cycle ticks (261 for 4 cycles). Change tempo to 2 mid-note → current note is unaffected, and the next note loads a 2-cycle tick.
- `restart` pulse during idx 5 → next cycle `freq`=0, `note_idx`=0, `busy`=0; with `play` high, 261 appears one cycle later. `rst` mid-note → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a fixed 16-entry melody ROM and drives the frequency
// of the current note (Hz) onto freq, with play/pause, restart, tempo select
// and optional looping from the last entry back to the first.
module melody_sequencer #(
    parameter int TICK_DIV = 6250000,
    parameter int LOOP     = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play,
    input  logic        restart,
    input  logic [1:0]  tempo,
    output logic [11:0] freq,
    output logic [3:0]  note_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [23:0] DIV_BASE = 24'(TICK_DIV);

    state_t      state, state_n;
    logic [23:0] cnt, cnt_n;
    logic [4:0]  rem, rem_n;
    logic [23:0] div, div_n;
    logic [11:0] freq_n;
    logic [3:0]  idx_n;
    logic        busy_n, done_n;

    logic [7:0]  cur_entry, nxt_entry;
    logic [3:0]  nxt_idx;
    logic        tick, note_end;

    // Melody ROM: {note code, duration field}; a note lasts field+1 ticks.
    function automatic logic [7:0] rom_entry(input logic [3:0] idx);
        logic [7:0] e;
        case (idx)
            4'd0:    e = {4'd1,  4'd0};
            4'd1:    e = {4'd3,  4'd0};
            4'd2:    e = {4'd5,  4'd0};
            4'd3:    e = {4'd6,  4'd0};
            4'd4:    e = {4'd8,  4'd1};
            4'd5:    e = {4'd10, 4'd1};
            4'd6:    e = {4'd12, 4'd1};
            4'd7:    e = {4'd0,  4'd0};
            4'd8:    e = {4'd2,  4'd3};
            4'd9:    e = {4'd4,  4'd0};
            4'd10:   e = {4'd7,  4'd0};
            4'd11:   e = {4'd9,  4'd0};
            4'd12:   e = {4'd11, 4'd0};
            4'd13:   e = {4'd13, 4'd0};
            4'd14:   e = {4'd10, 4'd15};
            default: e = {4'd1,  4'd0};
        endcase
        return e;
    endfunction

    // Note code to frequency in Hz; rests and unused codes are silent.
    function automatic logic [11:0] note_freq(input logic [3:0] code);
        logic [11:0] f;
        case (code)
            4'd1:    f = 12'd261;
            4'd2:    f = 12'd277;
            4'd3:    f = 12'd293;
            4'd4:    f = 12'd311;
            4'd5:    f = 12'd330;
            4'd6:    f = 12'd349;
            4'd7:    f = 12'd370;
            4'd8:    f = 12'd392;
            4'd9:    f = 12'd415;
            4'd10:   f = 12'd440;
            4'd11:   f = 12'd466;
            4'd12:   f = 12'd494;
            default: f = 12'd0;
        endcase
        return f;
    endfunction

    // Next-state and next-output logic; every register's next value is decided here.
    always_comb begin
        state_n   = state;
        idx_n     = note_idx;
        freq_n    = freq;
        cnt_n     = cnt;
        rem_n     = rem;
        div_n     = div;
        cur_entry = rom_entry(note_idx);
        nxt_idx   = note_idx + 4'd1;
        nxt_entry = rom_entry(nxt_idx);
        tick      = (state == PLAY) && (cnt == div - 24'd1);
        note_end  = tick && (rem == 5'd1);

        if (restart) begin
            state_n = IDLE;
            idx_n   = 4'd0;
            freq_n  = 12'd0;
            cnt_n   = 24'd0;
            rem_n   = 5'd0;
            div_n   = 24'd0;
        end else begin
            case (state)
                IDLE: begin
                    freq_n = 12'd0;
                    if (play) begin
                        state_n = PLAY;
                        freq_n  = note_freq(cur_entry[7:4]);
                        rem_n   = {1'b0, cur_entry[3:0]} + 5'd1;
                        cnt_n   = 24'd0;
                        div_n   = DIV_BASE >> tempo;
                    end
                end
                PLAY: begin
                    if (note_end) begin
                        if (note_idx == 4'd15 && LOOP == 0) begin
                            state_n = DONE;
                            freq_n  = 12'd0;
                            cnt_n   = 24'd0;
                            rem_n   = 5'd0;
                        end else begin
                            // Next entry loads on the ending tick; index wraps 15 -> 0.
                            idx_n  = nxt_idx;
                            freq_n = note_freq(nxt_entry[7:4]);
                            rem_n  = {1'b0, nxt_entry[3:0]} + 5'd1;
                            cnt_n  = 24'd0;
                            div_n  = DIV_BASE >> tempo;
                            if (!play) begin
                                state_n = PAUSE;
                                freq_n  = 12'd0;
                            end
                        end
                    end else if (!play) begin
                        state_n = PAUSE;
                        freq_n  = 12'd0;
                    end else if (tick) begin
                        cnt_n = 24'd0;
                        rem_n = rem - 5'd1;
                    end else begin
                        cnt_n = cnt + 24'd1;
                    end
                end
                PAUSE: begin
                    freq_n = 12'd0;
                    if (play) begin
                        state_n = PLAY;
                        freq_n  = note_freq(cur_entry[7:4]);
                    end
                end
                DONE: begin
                    freq_n = 12'd0;
                end
                default: begin
                    state_n = IDLE;
                    freq_n  = 12'd0;
                end
            endcase
        end

        busy_n = (state_n == PLAY) || (state_n == PAUSE);
        done_n = (state_n == DONE);
    end

    // State, counters and registered outputs; reset has top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            note_idx <= 4'd0;
            freq     <= 12'd0;
            cnt      <= 24'd0;
            rem      <= 5'd0;
            div      <= 24'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            note_idx <= idx_n;
            freq     <= freq_n;
            cnt      <= cnt_n;
            rem      <= rem_n;
            div      <= div_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: one non-looping and one looping
// instance share the same stimulus with TICK_DIV = 8.
module tb_melody_sequencer;

    logic        clk = 1'b0;
    logic        rst, play, restart;
    logic [1:0]  tempo;
    logic [11:0] freq_a, freq_b;
    logic [3:0]  idx_a, idx_b;
    logic        busy_a, busy_b, done_a, done_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    melody_sequencer #(.TICK_DIV(8), .LOOP(0)) u_dut (
        .clk(clk), .rst(rst), .play(play), .restart(restart), .tempo(tempo),
        .freq(freq_a), .note_idx(idx_a), .busy(busy_a), .done(done_a)
    );

    melody_sequencer #(.TICK_DIV(8), .LOOP(1)) u_loop (
        .clk(clk), .rst(rst), .play(play), .restart(restart), .tempo(tempo),
        .freq(freq_b), .note_idx(idx_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_note(input int f, input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("freq@%0d.%0d", idx, i), 32'(freq_a), 32'(f));
            check($sformatf("idx@%0d.%0d", idx, i), 32'(idx_a), 32'(idx));
            check($sformatf("busy@%0d.%0d", idx, i), 32'(busy_a), 32'd1);
            check($sformatf("loop_freq@%0d.%0d", idx, i), 32'(freq_b), 32'(f));
            step();
        end
    endtask

    task automatic check_quiet(input string tag, input int idx, input int bsy);
        check({tag, "_freq"}, 32'(freq_a), 32'd0);
        check({tag, "_idx"}, 32'(idx_a), 32'(idx));
        check({tag, "_busy"}, 32'(busy_a), 32'(bsy));
        check({tag, "_done"}, 32'(done_a), 32'd0);
        check({tag, "_loop_freq"}, 32'(freq_b), 32'd0);
    endtask

    int mel_f [16] = '{261, 293, 330, 349, 392, 440, 494, 0,
                       277, 311, 370, 415, 466, 0, 440, 261};
    int mel_n [16] = '{8, 8, 8, 8, 16, 16, 16, 8,
                       32, 8, 8, 8, 8, 8, 128, 8};

    initial begin
        rst = 1'b1; play = 1'b0; restart = 1'b0; tempo = 2'd0;
        step(); step();
        check_quiet("reset", 0, 0);
        check("reset_loop_busy", 32'(busy_b), 32'd0);

        // Idle with play low stays silent
        rst = 1'b0;
        step();
        check_quiet("idle", 0, 0);

        // Full melody at tempo 0
        play = 1'b1;
        step();
        for (int k = 0; k < 16; k++) run_note(mel_f[k], k, mel_n[k]);

        // Non-looping instance parks in DONE; looping instance wraps to entry 0
        for (int i = 0; i < 100; i++) begin
            check("done_level", 32'(done_a), 32'd1);
            check("done_freq", 32'(freq_a), 32'd0);
            check("done_idx", 32'(idx_a), 32'd15);
            check("done_busy", 32'(busy_a), 32'd0);
            if (i < 8) begin
                check("loop_wrap_freq", 32'(freq_b), 32'd261);
                check("loop_wrap_idx", 32'(idx_b), 32'd0);
                check("loop_wrap_done", 32'(done_b), 32'd0);
            end
            step();
        end

        // Restart from DONE
        play = 1'b0; restart = 1'b1;
        step();
        restart = 1'b0;
        check_quiet("restart_done", 0, 0);

        // Pause 3 cycles into entry 1, resume 20 cycles later
        play = 1'b1;
        step();
        run_note(261, 0, 8);
        run_note(293, 1, 3);
        play = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check_quiet("pause", 1, 1);
        end
        play = 1'b1;
        step();
        run_note(293, 1, 5);
        run_note(330, 2, 8);

        // Tempo 1 gives 4-cycle ticks; tempo 2 applies from the next note
        restart = 1'b1; play = 1'b0; tempo = 2'd1;
        step();
        restart = 1'b0;
        check_quiet("restart_tempo", 0, 0);
        play = 1'b1;
        step();
        run_note(261, 0, 4);
        run_note(293, 1, 2);
        tempo = 2'd2;
        run_note(293, 1, 2);
        run_note(330, 2, 2);
        run_note(349, 3, 2);
        run_note(392, 4, 4);
        run_note(440, 5, 2);

        // Restart pulse mid-note with play held high
        restart = 1'b1;
        step();
        restart = 1'b0;
        check_quiet("restart_pulse", 0, 0);
        step();
        run_note(261, 0, 1);

        // Synchronous reset mid-note
        rst = 1'b1;
        step();
        check_quiet("rst_mid", 0, 0);
        check("rst_mid_loop_idx", 32'(idx_b), 32'd0);

        // Restart together with play in IDLE delays entry by one cycle
        rst = 1'b0; restart = 1'b1;
        step();
        restart = 1'b0;
        check_quiet("restart_play_idle", 0, 0);
        step();
        run_note(261, 0, 2);

        // Play falls on a note-end tick: advance completes, then pause
        run_note(293, 1, 1);
        play = 1'b0;
        step();
        check_quiet("pause_at_end", 2, 1);
        play = 1'b1;
        step();
        run_note(330, 2, 2);
        run_note(349, 3, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
